// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller: opcodes, sequencer states,
// control-word bit positions and the one-hot T-state helper.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_JC  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ST_RESET is only held by the register; it resolves to T1 or WAIT from RUN.
  typedef enum logic [3:0] {
    ST_WAIT   = 4'd0,
    ST_T1     = 4'd1,
    ST_T2     = 4'd2,
    ST_T3     = 4'd3,
    ST_T4     = 4'd4,
    ST_T5     = 4'd5,
    ST_T6     = 4'd6,
    ST_HALTED = 4'd7,
    ST_RESET  = 4'd8
  } state_t;

  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_EJ = 2;
  localparam int CW_LM = 3;
  localparam int CW_CE = 4;
  localparam int CW_LI = 5;
  localparam int CW_EI = 6;
  localparam int CW_LA = 7;
  localparam int CW_EA = 8;
  localparam int CW_SU = 9;
  localparam int CW_EU = 10;
  localparam int CW_LB = 11;
  localparam int CW_LO = 12;
  localparam int CW_W  = 13;

  typedef logic [CW_W-1:0] cw_t;

  function automatic logic [5:0] t_onehot(input state_t s);
    logic [5:0] t;
    t = 6'b000000;
    case (s)
      ST_T1:   t = 6'b000001;
      ST_T2:   t = 6'b000010;
      ST_T3:   t = 6'b000100;
      ST_T4:   t = 6'b001000;
      ST_T5:   t = 6'b010000;
      ST_T6:   t = 6'b100000;
      default: t = 6'b000000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sap1_microcode_decoder.sv
// Combinational microcode ROM: (state, opcode, flags) -> control word, plus a
// flag marking instructions with no T5/T6 work.
module sap1_microcode_decoder
  import sap1_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zf,
  input  logic       cf,
  output cw_t        cw,
  output logic       short_instr
);

  always_comb begin
    cw          = '0;
    short_instr = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT});
    case (state)
      ST_T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      ST_T2: cw[CW_CP] = 1'b1;
      ST_T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_EI] = 1'b1;
            cw[CW_EJ] = 1'b1;
          end
          OP_JZ: begin
            cw[CW_EI] = zf;
            cw[CW_EJ] = zf;
          end
          OP_JC: begin
            cw[CW_EI] = cf;
            cw[CW_EJ] = cf;
          end
          OP_OUT: begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        if (opcode inside {OP_LDA, OP_ADD, OP_SUB}) begin
          cw[CW_CE] = 1'b1;
          cw[CW_LA] = (opcode == OP_LDA);
          cw[CW_LB] = (opcode != OP_LDA);
        end
      end
      ST_T6: begin
        if (opcode inside {OP_ADD, OP_SUB}) begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
          cw[CW_SU] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 ring with WAIT/HALTED states, single-step
// edge detect, and the decoded control word gated off while CLR is high.
module control_sequencer
  import sap1_pkg::*;
#(
  parameter bit SHORT_CYCLE = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Opcode,
  input  logic       Zf,
  input  logic       Cf,
  input  logic       RUN,
  input  logic       STEP,
  output logic       Cp,
  output logic       Ep,
  output logic       Ej,
  output logic       Lm,
  output logic       Ce,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic [5:0] T,
  output logic       HALT
);

  state_t state_q;
  state_t state;
  state_t state_nxt;
  state_t boundary;
  logic   step_q;
  logic   step_rise;
  cw_t    cw;
  cw_t    cw_out;
  logic   short_instr;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_RESET;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      step_q  <= STEP;
    end
  end

  // The reset state follows RUN live until the first clock after release.
  always_comb begin
    state = state_q;
    if (state_q == ST_RESET) state = RUN ? ST_T1 : ST_WAIT;
  end

  assign step_rise = STEP & ~step_q;
  assign boundary  = RUN ? ST_T1 : ST_WAIT;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:   state_nxt = (RUN || step_rise) ? ST_T1 : ST_WAIT;
      ST_T1:     state_nxt = ST_T2;
      ST_T2:     state_nxt = ST_T3;
      ST_T3:     state_nxt = ST_T4;
      ST_T4: begin
        if (Opcode == OP_HLT)                state_nxt = ST_HALTED;
        else if (SHORT_CYCLE && short_instr) state_nxt = boundary;
        else                                 state_nxt = ST_T5;
      end
      ST_T5:     state_nxt = ST_T6;
      ST_T6:     state_nxt = boundary;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = boundary;
    endcase
  end

  sap1_microcode_decoder u_decoder (
    .state       (state),
    .opcode      (Opcode),
    .zf          (Zf),
    .cf          (Cf),
    .cw          (cw),
    .short_instr (short_instr)
  );

  assign cw_out = CLR ? '0 : cw;

  assign Cp   = cw_out[CW_CP];
  assign Ep   = cw_out[CW_EP];
  assign Ej   = cw_out[CW_EJ];
  assign Lm   = cw_out[CW_LM];
  assign Ce   = cw_out[CW_CE];
  assign Li   = cw_out[CW_LI];
  assign Ei   = cw_out[CW_EI];
  assign La   = cw_out[CW_LA];
  assign Ea   = cw_out[CW_EA];
  assign Su   = cw_out[CW_SU];
  assign Eu   = cw_out[CW_EU];
  assign Lb   = cw_out[CW_LB];
  assign Lo   = cw_out[CW_LO];
  assign T    = t_onehot(state);
  assign HALT = (state == ST_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: long-cycle instance exercises reset,
// every opcode class, halt and single-step; a SHORT_CYCLE instance checks the early wrap.
module tb_control_sequencer;
  import sap1_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR, clr1;
  logic [3:0] Opcode;
  logic       Zf, Cf, RUN, STEP;

  logic Cp0, Ep0, Ej0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0, HALT0;
  logic Cp1, Ep1, Ej1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1, HALT1;
  logic [5:0] T0, T1s;
  cw_t obs0, obs1;

  int tests = 0;
  int fails = 0;

  localparam cw_t B1 = cw_t'(1);
  localparam cw_t W_T1  = (B1 << CW_EP) | (B1 << CW_LM);
  localparam cw_t W_T2  = (B1 << CW_CP);
  localparam cw_t W_T3  = (B1 << CW_CE) | (B1 << CW_LI);
  localparam cw_t W_MAR = (B1 << CW_EI) | (B1 << CW_LM);
  localparam cw_t W_JMP = (B1 << CW_EI) | (B1 << CW_EJ);
  localparam cw_t W_OUT = (B1 << CW_EA) | (B1 << CW_LO);
  localparam cw_t W_LDA5 = (B1 << CW_CE) | (B1 << CW_LA);
  localparam cw_t W_ALU5 = (B1 << CW_CE) | (B1 << CW_LB);
  localparam cw_t W_ADD6 = (B1 << CW_EU) | (B1 << CW_LA);
  localparam cw_t W_SUB6 = (B1 << CW_SU) | (B1 << CW_EU) | (B1 << CW_LA);

  cw_t exp_w [6];

  always #5 CLK = ~CLK;

  control_sequencer #(.SHORT_CYCLE(1'b0)) dut (
    .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .Zf(Zf), .Cf(Cf), .RUN(RUN), .STEP(STEP),
    .Cp(Cp0), .Ep(Ep0), .Ej(Ej0), .Lm(Lm0), .Ce(Ce0), .Li(Li0), .Ei(Ei0),
    .La(La0), .Ea(Ea0), .Su(Su0), .Eu(Eu0), .Lb(Lb0), .Lo(Lo0), .T(T0), .HALT(HALT0)
  );

  control_sequencer #(.SHORT_CYCLE(1'b1)) dut_short (
    .CLK(CLK), .CLR(clr1), .Opcode(Opcode), .Zf(Zf), .Cf(Cf), .RUN(RUN), .STEP(STEP),
    .Cp(Cp1), .Ep(Ep1), .Ej(Ej1), .Lm(Lm1), .Ce(Ce1), .Li(Li1), .Ei(Ei1),
    .La(La1), .Ea(Ea1), .Su(Su1), .Eu(Eu1), .Lb(Lb1), .Lo(Lo1), .T(T1s), .HALT(HALT1)
  );

  always_comb begin
    obs0 = '0;
    obs0[CW_CP] = Cp0; obs0[CW_EP] = Ep0; obs0[CW_EJ] = Ej0; obs0[CW_LM] = Lm0;
    obs0[CW_CE] = Ce0; obs0[CW_LI] = Li0; obs0[CW_EI] = Ei0; obs0[CW_LA] = La0;
    obs0[CW_EA] = Ea0; obs0[CW_SU] = Su0; obs0[CW_EU] = Eu0; obs0[CW_LB] = Lb0;
    obs0[CW_LO] = Lo0;
  end

  always_comb begin
    obs1 = '0;
    obs1[CW_CP] = Cp1; obs1[CW_EP] = Ep1; obs1[CW_EJ] = Ej1; obs1[CW_LM] = Lm1;
    obs1[CW_CE] = Ce1; obs1[CW_LI] = Li1; obs1[CW_EI] = Ei1; obs1[CW_LA] = La1;
    obs1[CW_EA] = Ea1; obs1[CW_SU] = Su1; obs1[CW_EU] = Eu1; obs1[CW_LB] = Lb1;
    obs1[CW_LO] = Lo1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starting at T1 of the long-cycle instance, check one full instruction.
  task automatic check_pass(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_T%0d", tag, i + 1), 32'(T0), 32'(1 << i));
      chk($sformatf("%s_cw%0d", tag, i + 1), 32'(obs0), 32'(exp_w[i]));
      tick();
    end
  endtask

  task automatic set_words(input cw_t w4, input cw_t w5, input cw_t w6);
    exp_w[0] = W_T1; exp_w[1] = W_T2; exp_w[2] = W_T3;
    exp_w[3] = w4;   exp_w[4] = w5;   exp_w[5] = w6;
  endtask

  initial begin
    CLR = 1'b1; clr1 = 1'b1; RUN = 1'b1; STEP = 1'b0;
    Opcode = OP_LDA; Zf = 1'b0; Cf = 1'b0;
    #2;
    chk("rst_T", 32'(T0), 32'h01);
    chk("rst_cw", 32'(obs0), 32'h0);
    chk("rst_halt", 32'(HALT0), 32'h0);
    RUN = 1'b0; #1;
    chk("rst_T_run0", 32'(T0), 32'h00);
    RUN = 1'b1;
    tick();
    CLR = 1'b0; #1;

    set_words(W_MAR, W_LDA5, '0);  check_pass("lda");
    Opcode = OP_ADD; set_words(W_MAR, W_ALU5, W_ADD6); check_pass("add");
    Opcode = OP_SUB; set_words(W_MAR, W_ALU5, W_SUB6); check_pass("sub");
    Opcode = OP_JZ; Zf = 1'b1; set_words(W_JMP, '0, '0); check_pass("jz1");
    Zf = 1'b0; set_words('0, '0, '0); check_pass("jz0");
    Opcode = OP_JC; Cf = 1'b1; set_words(W_JMP, '0, '0); check_pass("jc1");
    Cf = 1'b0; set_words('0, '0, '0); check_pass("jc0");
    Opcode = OP_JMP; set_words(W_JMP, '0, '0); check_pass("jmp");
    Opcode = OP_OUT; set_words(W_OUT, '0, '0); check_pass("out");
    Opcode = 4'h7; set_words('0, '0, '0); check_pass("nop");

    // CLR mid-T3 aborts the instruction and restarts fetch
    Opcode = OP_LDA;
    tick(); tick();
    chk("abort_pre_T", 32'(T0), 32'h04);
    CLR = 1'b1; #1;
    chk("abort_T", 32'(T0), 32'h01);
    chk("abort_cw", 32'(obs0), 32'h0);
    tick();
    CLR = 1'b0; #1;
    chk("abort_t1_cw", 32'(obs0), 32'(W_T1));
    tick();
    chk("abort_t2_cw", 32'(obs0), 32'(W_T2));
    chk("abort_t2_T", 32'(T0), 32'h02);

    // HLT: lock until CLR regardless of RUN/STEP
    Opcode = OP_HLT;
    tick(); tick();
    chk("hlt_T4", 32'(T0), 32'h08);
    chk("hlt_T4_cw", 32'(obs0), 32'h0);
    tick();
    chk("hlt_halt", 32'(HALT0), 32'h1);
    chk("hlt_T", 32'(T0), 32'h0);
    chk("hlt_cw", 32'(obs0), 32'h0);
    for (int i = 0; i < 20; i++) begin
      RUN = i[0]; STEP = i[1];
      tick();
      chk($sformatf("hlt_hold_halt%0d", i), 32'(HALT0), 32'h1);
      chk($sformatf("hlt_hold_T%0d", i), 32'(T0), 32'h0);
    end
    RUN = 1'b1; STEP = 1'b0;
    CLR = 1'b1; #1; CLR = 1'b0; #1;
    chk("hlt_clr_T", 32'(T0), 32'h01);
    chk("hlt_clr_halt", 32'(HALT0), 32'h0);

    // RUN dropped mid-instruction: finish it, then park in WAIT
    Opcode = OP_LDA;
    tick();
    RUN = 1'b0;
    chk("ss_T2", 32'(T0), 32'h02);
    tick(); tick(); tick(); tick();
    chk("ss_T6", 32'(T0), 32'h20);
    tick();
    chk("ss_wait", 32'(T0), 32'h0);
    chk("ss_wait_cw", 32'(obs0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ss_idle%0d", i), 32'(T0), 32'h0);
    end

    // STEP held high for 10 clocks gives exactly one instruction
    STEP = 1'b1;
    tick();
    chk("ss_step_T1", 32'(T0), 32'h01);
    chk("ss_step_cw", 32'(obs0), 32'(W_T1));
    for (int k = 1; k < 6; k++) begin
      tick();
      chk($sformatf("ss_step_T%0d", k + 1), 32'(T0), 32'(1 << k));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ss_held%0d", i), 32'(T0), 32'h0);
    end

    STEP = 1'b0;
    tick();
    STEP = 1'b1;
    tick();
    chk("ss_second_T1", 32'(T0), 32'h01);
    tick(); STEP = 1'b0;
    tick(); STEP = 1'b1;
    tick(); tick(); tick();
    chk("ss_second_T6", 32'(T0), 32'h20);
    tick();
    chk("ss_ignore0", 32'(T0), 32'h0);
    tick();
    chk("ss_ignore1", 32'(T0), 32'h0);

    // RUN raised mid-instruction resumes free run at the boundary
    STEP = 1'b0;
    tick();
    STEP = 1'b1;
    tick();
    chk("run_T1", 32'(T0), 32'h01);
    tick();
    RUN = 1'b1;
    tick(); tick(); tick(); tick();
    chk("run_T6", 32'(T0), 32'h20);
    tick();
    chk("run_resume_T1", 32'(T0), 32'h01);
    tick();
    chk("run_resume_T2", 32'(T0), 32'h02);
    STEP = 1'b0;

    // SHORT_CYCLE instance: JZ wraps to T1 after T4, LDA still reaches T5
    Opcode = OP_JZ; Zf = 1'b1;
    clr1 = 1'b0; #1;
    chk("sc_T1", 32'(T1s), 32'h01);
    tick(); tick(); tick();
    chk("sc_T4", 32'(T1s), 32'h08);
    chk("sc_T4_cw", 32'(obs1), 32'(W_JMP));
    tick();
    chk("sc_wrap", 32'(T1s), 32'h01);
    Opcode = OP_LDA;
    tick(); tick(); tick(); tick();
    chk("sc_lda_T5", 32'(T1s), 32'h10);
    chk("sc_lda_cw5", 32'(obs1), 32'(W_LDA5));
    chk("sc_halt", 32'(HALT1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
